// File: rtl/hdmi_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_pkg
// Shared HDMI transmitter definitions: the period-type encoding driven to the
// TMDS channel encoders, the preamble control patterns and packet geometry.
// ---------------------------------------------------------------------------
package hdmi_pkg;

  // Period type presented to the channel encoders.
  typedef enum logic [2:0] {
    MODE_CTRL     = 3'd0,
    MODE_VIDEO    = 3'd1,
    MODE_VIDEO_GB = 3'd2,
    MODE_DI_GB    = 3'd3,
    MODE_DI       = 3'd4
  } period_mode_t;

  // CTL3..CTL0 patterns announcing the following period.
  localparam logic [3:0] CTL_IDLE           = 4'b0000;
  localparam logic [3:0] CTL_PREAMBLE_DI    = 4'b0101;
  localparam logic [3:0] CTL_PREAMBLE_VIDEO = 4'b0001;

  localparam int PACKET_PIXELS   = 32;
  localparam int PREAMBLE_CYCLES = 8;
  localparam int GUARD_CYCLES    = 2;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/data_island_scheduler.sv
// ---------------------------------------------------------------------------
// data_island_scheduler
// Decides, pixel by pixel, which HDMI period is being transmitted: control,
// data-island preamble/guard/packets, or video preamble/guard/active video.
// One data island of N packets is placed in the horizontal blanking of every
// line; a video preamble is placed at the end of each line preceding an
// active line. All outputs are registered and describe the (cx, cy) sampled
// on the previous clk_pixel edge.
//
// Build option: define HDMI_DATA_ISLAND_EN to enable data islands. Without
// it the block schedules DVI timing only (no DI states, packet_enable = 0).
//
// Ports
//   clk_pixel            in   pixel clock
//   reset_n              in   synchronous active-low reset
//   cx, cy               in   pixel coordinates from the timing generator
//   mode                 out  period type (period_mode_t)
//   ctl                  out  preamble control bits, ctl[0] = CTL0
//   packet_enable        out  one-cycle strobe: advance to the next packet
//   packet_pixel_counter out  pixel index 0..31 within the current packet
//   video_field_end      out  one-cycle strobe at the last pixel of a frame
// ---------------------------------------------------------------------------
module data_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BIT_WIDTH     = 10,
  parameter int MAX_PACKETS   = 18
) (
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic [BIT_WIDTH-1:0] cy,
  output period_mode_t         mode,
  output logic [3:0]           ctl,
  output logic                 packet_enable,
  output logic [4:0]           packet_pixel_counter,
  output logic                 video_field_end
);

  // Packets that fit between the island start and the video preamble, with
  // preamble, guard bands and margin accounted for by the 38-pixel term.
  localparam int N_FIT      = (FRAME_WIDTH - SCREEN_WIDTH - 38) / PACKET_PIXELS;
  localparam int N          = min_int(MAX_PACKETS, N_FIT);
  localparam int PKT_CYCLES = PACKET_PIXELS * N;
  localparam int LEN_W      = (PKT_CYCLES > 8) ? $clog2(PKT_CYCLES) : 3;
  localparam int PKT_IDX_W  = (N > 1) ? $clog2(N) : 1;

  if (N < 1) begin : g_bad_config
    $error("data_island_scheduler: horizontal blanking too short for one packet");
  end

  localparam logic [LEN_W-1:0]     LEN_PRE_LAST = LEN_W'(PREAMBLE_CYCLES - 1);
  localparam logic [LEN_W-1:0]     LEN_GB_LAST  = LEN_W'(GUARD_CYCLES - 1);
  localparam logic [LEN_W-1:0]     LEN_PKT_LAST = LEN_W'(PKT_CYCLES - 1);
  localparam logic [PKT_IDX_W-1:0] PKT_IDX_LAST = PKT_IDX_W'(N - 1);
  localparam logic [4:0]           PIX_LAST     = 5'(PACKET_PIXELS - 1);

  localparam logic [BIT_WIDTH-1:0] CX_DI_START    = BIT_WIDTH'(SCREEN_WIDTH + 4);
  localparam logic [BIT_WIDTH-1:0] CX_VID_PRE     = BIT_WIDTH'(FRAME_WIDTH - 10);
  localparam logic [BIT_WIDTH-1:0] CX_ACTIVE_END  = BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [BIT_WIDTH-1:0] CX_LAST        = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0] CY_LAST        = BIT_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [BIT_WIDTH-1:0] CY_LAST_ACTIVE = BIT_WIDTH'(SCREEN_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_CTRL,
    S_DI_PRE,
    S_DI_LGB,
    S_DI_PKT,
    S_DI_TGB,
    S_VID_PRE,
    S_VID_GB,
    S_VIDEO
  } state_t;

  state_t                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [4:0]            r_ppc;
  logic [PKT_IDX_W-1:0]  r_pkt;
  period_mode_t          r_mode;
  logic [3:0]            r_ctl;
  logic                  r_pe;
  logic                  r_vfe;

  state_t                w_state_nxt;
  logic [LEN_W-1:0]      w_len_nxt;
  logic [4:0]            w_ppc_nxt;
  logic [PKT_IDX_W-1:0]  w_pkt_nxt;
  period_mode_t          w_mode_nxt;
  logic [3:0]            w_ctl_nxt;
  logic                  w_pe_nxt;
  logic                  w_vfe_nxt;
  logic                  w_next_line_active;
  logic                  w_di_start;

  assign w_next_line_active = (cy < CY_LAST_ACTIVE) || (cy == CY_LAST);

`ifdef HDMI_DATA_ISLAND_EN
  assign w_di_start = (cx == CX_DI_START);
`else
  assign w_di_start = 1'b0;
`endif

  // Next-state: the state computed here is the period for the sampled cx.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len + 1'b1;
    w_ppc_nxt   = '0;
    w_pkt_nxt   = '0;

    unique case (r_state)
      S_CTRL: begin
        w_len_nxt = '0;
        if (w_di_start) begin
          w_state_nxt = S_DI_PRE;
        end else if ((cx == CX_VID_PRE) && w_next_line_active) begin
          w_state_nxt = S_VID_PRE;
        end
      end
      S_DI_PRE: begin
        if (r_len == LEN_PRE_LAST) begin
          w_state_nxt = S_DI_LGB;
          w_len_nxt   = '0;
        end
      end
      S_DI_LGB: begin
        if (r_len == LEN_GB_LAST) begin
          w_state_nxt = S_DI_PKT;
          w_len_nxt   = '0;
        end
      end
      S_DI_PKT: begin
        if (r_len == LEN_PKT_LAST) begin
          w_state_nxt = S_DI_TGB;
          w_len_nxt   = '0;
        end else begin
          // 5-bit pixel counter wraps 31->0 on its own at packet boundaries.
          w_ppc_nxt = r_ppc + 5'd1;
          w_pkt_nxt = (r_ppc == PIX_LAST) ? r_pkt + 1'b1 : r_pkt;
        end
      end
      S_DI_TGB: begin
        if (r_len == LEN_GB_LAST) begin
          w_state_nxt = S_CTRL;
          w_len_nxt   = '0;
        end
      end
      S_VID_PRE: begin
        if (r_len == LEN_PRE_LAST) begin
          w_state_nxt = S_VID_GB;
          w_len_nxt   = '0;
        end
      end
      S_VID_GB: begin
        if (r_len == LEN_GB_LAST) begin
          w_state_nxt = S_VIDEO;
          w_len_nxt   = '0;
        end
      end
      S_VIDEO: begin
        w_len_nxt = '0;
        if (cx == CX_ACTIVE_END) begin
          w_state_nxt = S_CTRL;
        end
      end
      default: begin
        w_state_nxt = S_CTRL;
        w_len_nxt   = '0;
      end
    endcase

    // Line start outside the video lead-in means the timing generator jumped:
    // drop whatever was in progress rather than finish a broken island.
    if ((cx == '0) && (r_state != S_VID_GB) && (r_state != S_VIDEO)) begin
      w_state_nxt = S_CTRL;
      w_len_nxt   = '0;
      w_ppc_nxt   = '0;
      w_pkt_nxt   = '0;
    end
  end

  // Output decode from the next state, registered below.
  always_comb begin
    w_mode_nxt = MODE_CTRL;
    w_ctl_nxt  = CTL_IDLE;
    unique case (w_state_nxt)
      S_DI_PRE:           w_ctl_nxt  = CTL_PREAMBLE_DI;
      S_VID_PRE:          w_ctl_nxt  = CTL_PREAMBLE_VIDEO;
      S_DI_LGB, S_DI_TGB: w_mode_nxt = MODE_DI_GB;
      S_DI_PKT:           w_mode_nxt = MODE_DI;
      S_VID_GB:           w_mode_nxt = MODE_VIDEO_GB;
      S_VIDEO:            w_mode_nxt = MODE_VIDEO;
      default:            w_mode_nxt = MODE_CTRL;
    endcase
  end

`ifdef HDMI_DATA_ISLAND_EN
  // Strobe one cycle ahead of every packet's pixel 0: on the last leading
  // guard cycle, and on pixel 31 of every packet but the last.
  assign w_pe_nxt = ((w_state_nxt == S_DI_LGB) && (w_len_nxt == LEN_GB_LAST)) ||
                    ((w_state_nxt == S_DI_PKT) && (w_ppc_nxt == PIX_LAST) &&
                     (w_pkt_nxt != PKT_IDX_LAST));
`else
  assign w_pe_nxt = 1'b0;
`endif

  assign w_vfe_nxt = (cx == CX_LAST) && (cy == CY_LAST);

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_state <= S_CTRL;
      r_len   <= '0;
      r_ppc   <= '0;
      r_pkt   <= '0;
      r_mode  <= MODE_CTRL;
      r_ctl   <= CTL_IDLE;
      r_pe    <= 1'b0;
      r_vfe   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_ppc   <= w_ppc_nxt;
      r_pkt   <= w_pkt_nxt;
      r_mode  <= w_mode_nxt;
      r_ctl   <= w_ctl_nxt;
      r_pe    <= w_pe_nxt;
      r_vfe   <= w_vfe_nxt;
    end
  end

  assign mode                 = r_mode;
  assign ctl                  = r_ctl;
  assign packet_enable        = r_pe;
  assign packet_pixel_counter = r_ppc;
  assign video_field_end      = r_vfe;

endmodule

// File: tb/tb_data_island_scheduler.sv
// ---------------------------------------------------------------------------
// tb_data_island_scheduler
// Directed line-by-line stimulus at default parameters (800x525, 640x480,
// N = 3). Expected outputs come from the pixel ranges of the HDMI schedule
// written out by hand; DVI expectations apply when HDMI_DATA_ISLAND_EN is
// not defined.
// ---------------------------------------------------------------------------
module tb_data_island_scheduler;

`ifdef HDMI_DATA_ISLAND_EN
  localparam bit DI_ON = 1'b1;
`else
  localparam bit DI_ON = 1'b0;
`endif

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic [9:0] cx;
  logic [9:0] cy;
  logic [2:0] mode;
  logic [3:0] ctl;
  logic       packet_enable;
  logic [4:0] packet_pixel_counter;
  logic       video_field_end;

  int n_checks = 0;
  int n_errors = 0;
  bit prev_pre = 1'b0;

  always #5 clk_pixel = ~clk_pixel;

  data_island_scheduler dut (
    .clk_pixel            (clk_pixel),
    .reset_n              (reset_n),
    .cx                   (cx),
    .cy                   (cy),
    .mode                 (mode),
    .ctl                  (ctl),
    .packet_enable        (packet_enable),
    .packet_pixel_counter (packet_pixel_counter),
    .video_field_end      (video_field_end)
  );

  task automatic chk(input string tag, input int got, input int exp, input int x, input int y);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cx=%0d cy=%0d: got %0d, expected %0d", tag, x, y, got, exp);
    end
  endtask

  // Drive a coordinate, let the edge sample it, look at the result 1 ns later.
  task automatic step(input int x, input int y);
    cx = 10'(x);
    cy = 10'(y);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check_all(input string tag, input int x, input int y, input int em,
                           input int ectl, input int epe, input int eppc, input int evfe);
    chk({tag, ".mode"}, int'(mode), em, x, y);
    chk({tag, ".ctl"}, int'(ctl), ectl, x, y);
    chk({tag, ".pe"}, int'(packet_enable), epe, x, y);
    chk({tag, ".ppc"}, int'(packet_pixel_counter), eppc, x, y);
    chk({tag, ".vfe"}, int'(video_field_end), evfe, x, y);
  endtask

  // Samples with cx >= kill_from expect no island (abandoned earlier).
  task automatic run_line(input int y, input int x_lo, input int x_hi, input int kill_from);
    bit pre_next;
    pre_next = (y < 479) || (y == 524);
    for (int x = x_lo; x <= x_hi; x++) begin
      int em, ectl, epe, eppc, evfe;
      bit di;
      step(x, y);
      em = 0; ectl = 0; epe = 0; eppc = 0;
      di = DI_ON && (x < kill_from);
      if (x < 640)                                          em = prev_pre ? 1 : 0;
      else if (di && x >= 644 && x <= 651)                  ectl = 5;
      else if (di && (x == 652 || x == 653 || x == 750 || x == 751)) em = 3;
      else if (di && x >= 654 && x <= 749) begin
        em = 4;
        eppc = (x - 654) % 32;
      end
      else if (pre_next && x >= 790 && x <= 797)            ectl = 1;
      else if (pre_next && x >= 798)                        em = 2;
      if (di && (x == 653 || x == 685 || x == 717)) epe = 1;
      evfe = (x == 799 && y == 524) ? 1 : 0;
      check_all("line", x, y, em, ectl, epe, eppc, evfe);
    end
    if (x_hi == 799) prev_pre = pre_next;
  endtask

  initial begin
    reset_n = 1'b0;
    cx = 10'd700;
    cy = 10'd0;
    for (int i = 0; i < 3; i++) begin
      step(700, 0);
      check_all("reset", 700, 0, 0, 0, 0, 0, 0);
    end
    reset_n = 1'b1;
    prev_pre = 1'b0;

    run_line(9, 0, 799, 800);
    run_line(10, 0, 799, 800);
    run_line(11, 0, 799, 800);

    // Reset in the middle of an island.
    run_line(20, 0, 699, 800);
    reset_n = 1'b0;
    for (int x = 700; x <= 702; x++) begin
      step(x, 20);
      check_all("midreset", x, 20, 0, 0, 0, 0, 0);
    end
    reset_n = 1'b1;
    run_line(20, 703, 799, 0);
    run_line(21, 0, 799, 800);

    // Timing generator jumps to cx=0 mid-island.
    run_line(30, 0, 670, 800);
    step(0, 30);
    check_all("resync", 0, 30, 0, 0, 0, 0, 0);
    run_line(30, 671, 799, 0);

    // Frame-edge lines: last active line, blanking, wrap to next frame.
    run_line(478, 0, 799, 800);
    run_line(479, 0, 799, 800);
    run_line(480, 0, 799, 800);
    run_line(500, 0, 799, 800);
    run_line(523, 0, 799, 800);
    run_line(524, 0, 799, 800);
    run_line(0, 0, 799, 800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_island_scheduler.md
DATA_ISLAND_SCHEDULER -- requirements
Module: data_island_scheduler

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 800, meaning total pixels per line including blanking.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 525, meaning total lines per frame.
REQ-003 SHALL have parameter SCREEN_WIDTH, default 640, meaning active pixels per line; active region is cx < SCREEN_WIDTH.
REQ-004 SHALL have parameter SCREEN_HEIGHT, default 480, meaning active lines; active region is cy < SCREEN_HEIGHT.
REQ-005 SHALL have parameter BIT_WIDTH, default 10, meaning width of cx and cy.
REQ-006 SHALL have parameter MAX_PACKETS, default 18, meaning upper bound on packets per data island.
REQ-007 SHALL have port clk_pixel, input, 1, pixel clock; the only clock.
REQ-008 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have ports cx and cy, input, BIT_WIDTH each, current pixel coordinates from the timing generator.
REQ-010 SHALL have port mode, output, 3, period type, encoded as period_mode_t.
REQ-011 SHALL have port ctl, output, 4, preamble control bits; ctl[0] is CTL0.
REQ-012 SHALL have port packet_enable, output, 1, one-cycle strobe telling the packet picker to select the next packet.
REQ-013 SHALL have port packet_pixel_counter, output, 5, pixel index 0..31 within the current packet.
REQ-014 SHALL have port video_field_end, output, 1, one-cycle end-of-field strobe.

Function
REQ-015 SHALL register all outputs; the outputs for a sampled (cx,cy) SHALL appear one clk_pixel cycle later.
REQ-016 SHALL use localparam N = min(MAX_PACKETS, (FRAME_WIDTH-SCREEN_WIDTH-38)/32); N<1 SHALL be an elaboration error.
REQ-017 SHALL use states CTRL, DI_PRE, DI_LGB, DI_PKT, DI_TGB, VID_PRE, VID_GB, VIDEO, each timed by an internal length counter.
REQ-018 CTRL->DI_PRE SHALL occur on every line (active and blanking) when cx==SCREEN_WIDTH+4.
REQ-019 State lengths: DI_PRE 8 cycles, DI_LGB 2, DI_PKT 32*N, DI_TGB 2, then return to CTRL.
REQ-020 CTRL->VID_PRE SHALL occur at cx==FRAME_WIDTH-10 only when the next line is active (cy<SCREEN_HEIGHT-1 or cy==FRAME_HEIGHT-1); VID_PRE lasts 8 cycles, VID_GB 2, then VIDEO.
REQ-021 VIDEO SHALL persist while cx<SCREEN_WIDTH and exit to CTRL when cx==SCREEN_WIDTH.
REQ-022 mode SHALL be: CTRL/DI_PRE/VID_PRE->MODE_CTRL; DI_LGB/DI_TGB->MODE_DI_GB; DI_PKT->MODE_DI; VID_GB->MODE_VIDEO_GB; VIDEO->MODE_VIDEO.
REQ-023 ctl SHALL be 4'b0101 in DI_PRE, 4'b0001 in VID_PRE, and 4'b0000 otherwise.
REQ-024 packet_pixel_counter SHALL count 0..31 repeatedly in DI_PKT, wrapping 31->0 between packets, and SHALL hold 0 outside DI_PKT.
REQ-025 packet_enable SHALL be high for exactly one cycle immediately before each packet's pixel 0 (last DI_LGB cycle, or counter==31 with packets remaining): exactly N strobes per island.
REQ-026 video_field_end SHALL pulse for one cycle for sampled cx==FRAME_WIDTH-1 and cy==FRAME_HEIGHT-1.
REQ-027 Resync: a sampled cx==0 in any state other than VID_GB or VIDEO SHALL force CTRL, clear the counters and suppress packet_enable; a partial island SHALL NOT resume.
REQ-028 A sampled cx==SCREEN_WIDTH+4 while an island is in progress SHALL be ignored.

Reset
REQ-029 While reset_n is low at a clk_pixel edge: state=CTRL, mode=MODE_CTRL, ctl=0, packet_enable=0, packet_pixel_counter=0, video_field_end=0, internal counters=0.
REQ-030 Reset mid-island SHALL abandon the island; the first island after reset begins at the next cx==SCREEN_WIDTH+4.

Configuration
REQ-031 With HDMI_DATA_ISLAND_EN defined, behaviour SHALL be as above.
REQ-032 Without HDMI_DATA_ISLAND_EN (DVI mode), no DI_* state SHALL be entered, packet_enable SHALL be constant 0, ctl SHALL never be 4'b0101, and video scheduling and video_field_end SHALL be unchanged.

Structure
REQ-033 Shared package hdmi_pkg SHALL hold period_mode_t (MODE_CTRL=0, MODE_VIDEO=1, MODE_VIDEO_GB=2, MODE_DI_GB=3, MODE_DI=4), the preamble constants and PACKET_PIXELS=32; the state enum SHALL be local.
REQ-034 No sub-module SHALL be used; the length counter and packet counter SHALL be inline.

Verification (defaults, N=3; cycle numbers are sampled cx, outputs one cycle later)
REQ-035 Line cy=10: cx 644-651 gives ctl=0101; 652-653 MODE_DI_GB; 654-749 MODE_DI; 750-751 MODE_DI_GB; packet_enable at cx 653, 685, 717 only.
REQ-036 cy=10: cx 790-797 gives ctl=0001; 798-799 MODE_VIDEO_GB; cx 0..639 of cy=11 MODE_VIDEO. cy=479 and cy=500: no video preamble. cy=524: preamble present.
REQ-037 cx=799, cy=524 gives a single video_field_end pulse; no other cycle in the frame asserts it.
REQ-038 reset_n low at cx=700 for 3 cycles: all outputs 0 and MODE_CTRL the cycle after; no packet_enable until cx=653 of the next line.
REQ-039 Force cx from 670 to 0 mid-island: next cycle MODE_CTRL, counter 0, no further packet_enable on that line.
REQ-040 Built without HDMI_DATA_ISLAND_EN: a full frame shows packet_enable=0 throughout and no MODE_DI/MODE_DI_GB, while the video timing matches REQ-036.
